spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI responder (slave) for the 16-bit SPI master in tarea3: receives a DATA_WIDTH-bit word on MOSI and returns a DATA_WIDTH-bit word on MISO in the same frame.
- Runs on the local system clock; SCLK, CS_N and MOSI are treated as asynchronous inputs and oversampled.
- Local side: tx buffer with a valid/ready handshake, rx word with a valid/ack handshake.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, one word per CS_N assertion.

Parameters:
- DATA_WIDTH, 16, frame length in bits; also the width of tx_data and rx_data.

Ports:
- clk  input  1  system clock; fclk >= 4 x fSCLK.
- reset  input  1  asynchronous, active-high.
- SCLK  input  1  SPI clock from the master; idles low.
- CS_N  input  1  chip select, active-low.
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master.
- tx_data  input  DATA_WIDTH  word to send in the next frame.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  tx buffer is empty; a load is accepted when tx_valid & tx_ready.
- rx_data  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  rx_data is valid; held high until rx_ack.
- rx_ack  input  1  consumer has taken rx_data.
- busy  output  1  high while state is SHIFT or DONE.
- rx_overrun  output  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset values (asynchronous, active-high): MISO=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, rx_overrun=0, state=IDLE, bit_cnt=0, shift registers=0, tx buffer empty, all synchronizer flops=0 except CS_N flops, which reset to 1.
- Synchronization:
  - SCLK, CS_N and MOSI each pass through a 2-flop synchronizer.
  - A third flop holds the previous synchronized value for edge detection.
  - sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3; cs_fall and cs_rise are decoded the same way.
- tx buffer:
  - On tx_valid & tx_ready, capture tx_data and drive tx_ready low on the next clk.
  - On a cs_fall in IDLE, the buffer moves into tx_shift and tx_ready goes high on the next clk.
  - If the buffer is empty at cs_fall, tx_shift loads all zeros.
- State machine (IDLE, SHIFT, DONE):
  - IDLE: MISO=0. On cs_fall: load tx_shift, MISO=tx_shift MSB, bit_cnt=0, go to SHIFT.
  - SHIFT, on sclk_rise: rx_shift <= {rx_shift[DATA_WIDTH-2:0], MOSI_sync}; bit_cnt++.
  - SHIFT, on sclk_fall while bit_cnt < DATA_WIDTH: shift tx_shift left and drive MISO with the new MSB.
  - SHIFT, on the sclk_rise that brings bit_cnt to DATA_WIDTH: on the next clk, rx_data <= the full word, rx_valid=1, go to DONE.
  - DONE: MISO=0; all SCLK edges are ignored; on cs_rise go to IDLE.
  - cs_rise while in SHIFT (frame aborted mid-word): go to IDLE, bit_cnt=0, MISO=0. rx_data and rx_valid are unchanged and the partial word is discarded.
  - cs_fall and sclk_rise in the same clk: the cs_fall is processed and the SCLK edge is ignored; the master must not do this.
- Latency: rx_valid rises exactly 3 clk rising edges after the first clk edge at which SCLK is sampled high for the last bit.
- rx handshake: rx_ack while rx_valid is high clears rx_valid on the next clk. A frame completion in the same cycle as rx_ack has priority: new data is loaded and rx_valid stays 1.
- Widths: bit_cnt is $clog2(DATA_WIDTH)+1 bits wide and never wraps; it saturates at DATA_WIDTH in DONE.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - A frame that completes while rx_valid=1 (and rx_ack is not asserted in that cycle) sets rx_overrun=1.
  - rx_overrun is sticky until reset.
  - The new word overwrites rx_data.
- Undefined: rx_overrun is tied to 0, and the overwrite of rx_data still occurs.

Test Plan:
- Basic exchange: load tx_data=16'hA5C3, then run a mode-0 frame with MOSI=16'h1234 at fSCLK=fclk/8 -> MISO bits read A5C3 MSB first; rx_data=16'h1234 with rx_valid=1 exactly 3 clk after the 16th SCLK rise; tx_ready=1 after cs_fall.
- Empty tx buffer: run a frame with no tx load -> MISO=0 for all 16 bits; rx_data is still captured correctly.
- Abort: raise CS_N after 7 SCLK rises -> state returns to IDLE, rx_valid stays 0, and the next full frame with MOSI=16'hFFFF gives rx_data=16'hFFFF.
- Overrun: two back-to-back frames (16'h0001, 16'h0002) with no rx_ack -> rx_data=16'h0002; rx_overrun=1 with SPI_SLAVE_OVERRUN_EN defined, 0 without it.
- Extra clocks: 20 SCLK pulses in one CS_N window -> only the first 16 bits are captured, MISO=0 after bit 16, busy=1 until CS_N rises.
- Reset mid-frame: assert reset after 5 bits -> all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder with oversampled SCLK/CS_N/MOSI, a one-word tx buffer and an rx word with valid/ack.
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky rx_overrun flag; otherwise rx_overrun is tied low.
module spi_slave #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic                  rx_overrun
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Two synchronizer stages plus a history flop for edge decoding.
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts one stage per clk.
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      cs_sync_q   <= {cs_sync_q[1:0], CS_N};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  frame_done;
  logic                  buf_taken;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    miso_d     = miso_q;
    frame_done = 1'b0;
    buf_taken  = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          tx_shift_d = tx_full_q ? tx_buf_q : '0;
          miso_d     = tx_full_q ? tx_buf_q[DATA_WIDTH-1] : 1'b0;
          bit_cnt_d  = '0;
          buf_taken  = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          bit_cnt_d = '0;
          miso_d    = 1'b0;
          state_d   = IDLE;
        end else if (bit_cnt_q == LAST_CNT) begin
          frame_done = 1'b1;
          miso_d     = 1'b0;
          state_d    = DONE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          miso_d     = tx_shift_q[DATA_WIDTH-2];
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Completion wins over a same-cycle ack so a fresh word is never dropped.
    if (frame_done) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

    if (buf_taken) tx_full_d = 1'b0;
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (frame_done && rx_valid_q && !rx_ack) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign rx_overrun = overrun_q;
`else
  assign rx_overrun = 1'b0;
`endif

  assign MISO     = miso_q;
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);

endmodule
